// File: rtl/uart_digit_display.sv
// uart_digit_display
//   Turns bytes from the UART receiver into a multi-digit entry buffer and
//   drives a time-multiplexed 7-segment display with the committed value.
//   Typed digits shift in from the right, CR commits, BS deletes the last
//   digit, 'C'/'c' clears the entry, LF is ignored, and anything else is
//   rejected with a one-cycle err pulse.
//
// Parameters
//   NUM_DIGITS  number of display digits (2..8)
//   SCAN_DIV    clk cycles each digit stays enabled (>=2)
//
// Ports
//   clk        system clock, all logic on posedge
//   reset_n    synchronous active-low reset
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte-ready level from the UART RX; only its rising edge counts
//   seg        active-high segment pattern of the enabled digit
//   digit_en   one-hot digit enable, bit 0 = rightmost digit
//   value_bcd  committed value, BCD, digit i at [4i+3:4i]
//   err        one-cycle pulse when a byte is rejected
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the highest
//   non-zero digit are blanked; digit 0 is always shown.

module uart_digit_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 27000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic                    err
);

  localparam int VW     = 4 * NUM_DIGITS;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic {
    P_IDLE,
    P_DECODE
  } parseState_t;

  // ---------------------------------------------------------------- parser
  parseState_t      state, stateNext;
  logic             rxValidQ;
  logic             rxEdge;
  logic [7:0]       byteQ, byteNext;
  logic [VW-1:0]    entry, entryNext;
  logic [CNT_W-1:0] count, countNext;
  logic [VW-1:0]    valueNext;
  logic             errNext;
  logic             isDigit;

  assign rxEdge = rx_valid && !rxValidQ;

  // Raw 0x08 is backspace, so the raw digit range effectively excludes it;
  // the BS test below is ordered ahead of the digit test for that reason.
  assign isDigit = ((byteQ[7:4] == 4'h3) || (byteQ[7:4] == 4'h0)) &&
                   (byteQ[3:0] <= 4'h9);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= P_IDLE;
      rxValidQ  <= 1'b1;
      byteQ     <= '0;
      entry     <= '0;
      count     <= '0;
      value_bcd <= '0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      rxValidQ  <= rx_valid;
      byteQ     <= byteNext;
      entry     <= entryNext;
      count     <= countNext;
      value_bcd <= valueNext;
      err       <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    byteNext  = byteQ;
    entryNext = entry;
    countNext = count;
    valueNext = value_bcd;
    errNext   = 1'b0;
    case (state)
      P_IDLE: begin
        if (rxEdge) begin
          byteNext  = rx_data;
          stateNext = P_DECODE;
        end
      end
      P_DECODE: begin
        stateNext = P_IDLE;
        if (byteQ == 8'h08) begin
          if (count == '0) begin
            errNext = 1'b1;
          end else begin
            entryNext = {4'h0, entry[VW-1:4]};
            countNext = count - 1'b1;
          end
        end else if (isDigit) begin
          if (count < CNT_W'(NUM_DIGITS)) begin
            entryNext = {entry[VW-5:0], byteQ[3:0]};
            countNext = count + 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end else if (byteQ == 8'h0D) begin
          valueNext = entry;
          entryNext = '0;
          countNext = '0;
        end else if ((byteQ == 8'h43) || (byteQ == 8'h63)) begin
          entryNext = '0;
          countNext = '0;
        end else if (byteQ != 8'h0A) begin
          errNext = 1'b1;
        end
      end
      default: stateNext = P_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ scan
  logic [SCAN_W-1:0]     scanCnt;
  logic [IDX_W-1:0]      digitIdx;
  logic [3:0]            digitVal [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] enNext;
  logic [6:0]            segNext;

  function automatic logic [6:0] segDecode(input logic [3:0] d);
    case (d)
      4'd0:    segDecode = 7'h3F;
      4'd1:    segDecode = 7'h09;
      4'd2:    segDecode = 7'h5E;
      4'd3:    segDecode = 7'h5B;
      4'd4:    segDecode = 7'h69;
      4'd5:    segDecode = 7'h73;
      4'd6:    segDecode = 7'h77;
      4'd7:    segDecode = 7'h19;
      4'd8:    segDecode = 7'h7F;
      4'd9:    segDecode = 7'h7B;
      default: segDecode = 7'h00;
    endcase
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digitVal[i] = value_bcd[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blank while no
  // non-zero digit has been seen above it. Digit 0 is never blanked.
  always_comb begin
    logic seenNz;
    seenNz = 1'b0;
    blank  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (value_bcd[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) begin
        seenNz = 1'b1;
      end
      if ((k != NUM_DIGITS - 1) && !seenNz) begin
        blank[NUM_DIGITS-1-k] = 1'b1;
      end
    end
  end
`else
  assign blank = '0;
`endif

  assign enNext  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digitIdx;
  assign segNext = blank[digitIdx] ? 7'h00 : segDecode(digitVal[digitIdx]);

  // seg and digit_en are registered together so both switch on one edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scanCnt  <= '0;
      digitIdx <= '0;
      digit_en <= '0;
      seg      <= '0;
    end else begin
      if (scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
        scanCnt  <= '0;
        digitIdx <= (digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx + 1'b1;
      end else begin
        scanCnt <= scanCnt + 1'b1;
      end
      digit_en <= enNext;
      seg      <= segNext;
    end
  end

endmodule

// File: tb/tb_uart_digit_display.sv
module tb_uart_digit_display;

  localparam int ND = 4;
  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic [15:0] value_bcd;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        e;
    logic [15:0] v;
    int          c;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monX;
  logic [15:0] lastVal = '0;
  logic [15:0] prevVal = '0;

  uart_digit_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .seg      (seg),
    .digit_en (digit_en),
    .value_bcd(value_bcd),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  // Monitor: every err pulse or change of value_bcd is a DUT response.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevVal = value_bcd;
    end else if (err || (value_bcd != prevVal)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got err=%0b value=%h at cyc %0d, expected none",
                 err, value_bcd, cyc);
      end else begin
        monX = sbq.pop_front();
        if ((monX.e !== err) || (monX.v !== value_bcd) || (monX.c != cyc)) begin
          errors++;
          $display("FAIL event: got err=%0b value=%h cyc=%0d, expected err=%0b value=%h cyc=%0d",
                   err, value_bcd, cyc, monX.e, monX.v, monX.c);
        end
      end
      prevVal = value_bcd;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Send one byte; e/v are the hand-computed err and committed value after it.
  task automatic sendByte(input logic [7:0] b, input logic e, input logic [15:0] v,
                          input int hold);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (e || (v != lastVal)) sbq.push_back('{e, v, cyc + 2});
    lastVal = v;
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic checkDigit(input int i, input logic [6:0] expSeg);
    logic found;
    logic [3:0] want;
    found = 1'b0;
    want  = 4'b0001 << i;
    for (int n = 0; n < 4 * SD + 4; n++) begin
      @(negedge clk);
      if (digit_en == want) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL digit_timeout: digit_en=%b never reached %b", digit_en, want);
    end else begin
      chk($sformatf("seg_digit%0d", i), {25'b0, seg}, {25'b0, expSeg});
    end
  endtask

  initial begin
    logic [3:0] expEn;
    reset_n  = 1'b0;
    rx_valid = 1'b1;        // level already high during reset: must not count
    rx_data  = 8'h39;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", {25'b0, seg}, 32'h0);
    chk("rst_digit_en", {28'b0, digit_en}, 32'h0);
    chk("rst_value", {16'b0, value_bcd}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // T1: scan sequence with value 0
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      expEn = 4'b0001 << (((k - 1) / SD) % 4);
      chk($sformatf("scan_en_k%0d", k), {28'b0, digit_en}, {28'b0, expEn});
      chk($sformatf("scan_seg_k%0d", k), {25'b0, seg},
          (expEn == 4'b0001) ? 32'h3F : {25'b0, LZ});
      if (k == 20) rx_valid = 1'b0;
    end

    // T2
    sendByte(8'h31, 1'b0, 16'h0000, 1);
    sendByte(8'h32, 1'b0, 16'h0000, 1);
    sendByte(8'h33, 1'b0, 16'h0000, 1);
    sendByte(8'h0D, 1'b0, 16'h0123, 1);
    checkDigit(0, 7'h5B);
    checkDigit(1, 7'h5E);
    checkDigit(2, 7'h09);
    checkDigit(3, LZ);

    // T3: fifth digit overflows
    sendByte(8'h39, 1'b0, 16'h0123, 1);
    sendByte(8'h38, 1'b0, 16'h0123, 1);
    sendByte(8'h37, 1'b0, 16'h0123, 1);
    sendByte(8'h36, 1'b0, 16'h0123, 1);
    sendByte(8'h35, 1'b1, 16'h0123, 1);
    sendByte(8'h0D, 1'b0, 16'h9876, 1);
    checkDigit(3, 7'h7B);

    // T4: backspace, bad bytes, LF, raw digits, lowercase clear
    sendByte(8'h34, 1'b0, 16'h9876, 1);
    sendByte(8'h32, 1'b0, 16'h9876, 1);
    sendByte(8'h08, 1'b0, 16'h9876, 1);
    sendByte(8'h0D, 1'b0, 16'h0004, 1);
    sendByte(8'h08, 1'b1, 16'h0004, 1);
    sendByte(8'h78, 1'b1, 16'h0004, 1);
    sendByte(8'h0A, 1'b0, 16'h0004, 1);
    sendByte(8'h03, 1'b0, 16'h0004, 1);
    sendByte(8'h07, 1'b0, 16'h0004, 1);
    sendByte(8'h0D, 1'b0, 16'h0037, 1);
    sendByte(8'h31, 1'b0, 16'h0037, 1);
    sendByte(8'h63, 1'b0, 16'h0037, 1);
    sendByte(8'h0D, 1'b0, 16'h0000, 1);

    // T5: long level counts once; 'C' clears
    sendByte(8'h37, 1'b0, 16'h0000, 500);
    sendByte(8'h0D, 1'b0, 16'h0007, 1);
    sendByte(8'h35, 1'b0, 16'h0007, 1);
    sendByte(8'h43, 1'b0, 16'h0007, 1);
    sendByte(8'h0D, 1'b0, 16'h0000, 1);

    // T6: reset one cycle after a byte edge
    sendByte(8'h36, 1'b0, 16'h0000, 1);
    sendByte(8'h0D, 1'b0, 16'h0006, 1);
    @(posedge clk);
    #1;
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_value", {16'b0, value_bcd}, 32'h0);
    chk("t6_err", {31'b0, err}, 32'h0);
    chk("t6_digit_en", {28'b0, digit_en}, 32'h0);
    #1 reset_n = 1'b1;
    lastVal = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk("t6_scan_restart", {28'b0, digit_en}, 32'h1);
    chk("t6_seg0", {25'b0, seg}, 32'h3F);
    sendByte(8'h0D, 1'b0, 16'h0000, 1);
    sendByte(8'h38, 1'b0, 16'h0000, 1);
    sendByte(8'h0D, 1'b0, 16'h0008, 1);

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
